// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - raster-order pixel dispatcher feeding a pool of compute engines
// Round-robin grant with a one-cycle per-engine cooldown; registered grant and coordinate outputs.
module pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int X_RES       = 640,
  parameter int Y_RES       = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_ENGINES-1:0] engine_idle,
  input  logic [NUM_ENGINES-1:0] queue_full,
  output logic [NUM_ENGINES-1:0] dispatch,
  output logic [DATA_WIDTH-1:0]  xpixel_o,
  output logic [DATA_WIDTH-1:0]  ypixel_o,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int RW = $clog2(NUM_ENGINES);
  localparam logic [DATA_WIDTH-1:0] LAST_X = DATA_WIDTH'(X_RES - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_Y = DATA_WIDTH'(Y_RES - 1);
  localparam logic [RW-1:0]         LAST_E = RW'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [DATA_WIDTH-1:0]   xo_q, xo_d, yo_q, yo_d;
  logic [RW-1:0]           rr_q, rr_d;
  logic [NUM_ENGINES-1:0]  disp_q, disp_d;
  logic [NUM_ENGINES-1:0]  eligible;
  logic                    found;
  logic [RW-1:0]           grant_idx;

  // The registered grant doubles as the cooldown mask: it is exactly last cycle's grant.
  assign eligible = engine_idle & ~queue_full & ~disp_q;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && eligible[(int'(rr_q) + k) % NUM_ENGINES]) begin
        found     = 1'b1;
        grant_idx = RW'((int'(rr_q) + k) % NUM_ENGINES);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rr_d    = rr_q;
    disp_d  = '0;
    xo_d    = xo_q;
    yo_d    = yo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DISPATCH;
          x_d     = '0;
          y_d     = '0;
          rr_d    = '0;
        end
      end
      DISPATCH: begin
        if (found) begin
          disp_d = NUM_ENGINES'(1) << grant_idx;
          xo_d   = x_q;
          yo_d   = y_q;
          rr_d   = (grant_idx == LAST_E) ? '0 : grant_idx + RW'(1);
          if (x_q == LAST_X) begin
            x_d = '0;
            if (y_q == LAST_Y) state_d = DRAIN;
            else               y_d     = y_q + DATA_WIDTH'(1);
          end else begin
            x_d = x_q + DATA_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (disp_q == '0 && &engine_idle) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rr_q    <= '0;
      disp_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rr_q    <= rr_d;
      disp_q  <= disp_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end

  assign dispatch   = disp_q;
  assign xpixel_o   = xo_q;
  assign ypixel_o   = yo_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb/tb_pixel_scheduler.sv - bench for pixel_scheduler on a 2-engine, 4x2 frame
// A pixel-index model is compared every cycle; directed scenarios add literal expectations.
module tb_pixel_scheduler;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int XR = 4;
  localparam int YR = 2;
  localparam int TOTAL = XR * YR;

  logic          clk;
  logic          reset;
  logic          start;
  logic [N-1:0]  engine_idle;
  logic [N-1:0]  queue_full;
  logic [N-1:0]  dispatch;
  logic [DW-1:0] xpixel_o;
  logic [DW-1:0] ypixel_o;
  logic          busy;
  logic          frame_done;

  pixel_scheduler #(.NUM_ENGINES(N), .DATA_WIDTH(DW), .X_RES(XR), .Y_RES(YR)) dut (
    .clk(clk), .reset(reset), .start(start), .engine_idle(engine_idle),
    .queue_full(queue_full), .dispatch(dispatch), .xpixel_o(xpixel_o),
    .ypixel_o(ypixel_o), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int n_done = 0;
  int log_eng[$];
  int log_x[$];
  int log_y[$];

  // Model: phase 0 idle, 1 handing out pixels, 2 waiting for engines, 3 done pulse.
  int m_phase = 0;
  int m_n = 0;
  int m_rr = 0;
  int m_disp = -1;
  int m_cx = 0;
  int m_cy = 0;

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare_and_model
    logic [N-1:0] exp_disp;
    int nd;
    int g;
    if (check_en) begin
      exp_disp = (m_disp < 0) ? '0 : (N'(1) << m_disp);
      checks++;
      if (dispatch !== exp_disp) begin
        errors++;
        $display("FAIL dispatch: got %b expected %b at %0t", dispatch, exp_disp, $time);
      end
      if (m_disp >= 0) begin
        checks++;
        if (xpixel_o !== 32'(m_cx)) begin
          errors++;
          $display("FAIL xpixel: got %0d expected %0d at %0t", xpixel_o, m_cx, $time);
        end
        checks++;
        if (ypixel_o !== 32'(m_cy)) begin
          errors++;
          $display("FAIL ypixel: got %0d expected %0d at %0t", ypixel_o, m_cy, $time);
        end
      end
      checks++;
      if (busy !== (m_phase != 0)) begin
        errors++;
        $display("FAIL busy: got %b expected %b at %0t", busy, (m_phase != 0), $time);
      end
      checks++;
      if (frame_done !== (m_phase == 3)) begin
        errors++;
        $display("FAIL frame_done: got %b expected %b at %0t", frame_done, (m_phase == 3), $time);
      end
      for (int e = 0; e < N; e++) begin
        if (dispatch[e] === 1'b1) begin
          log_eng.push_back(e);
          log_x.push_back(int'(xpixel_o));
          log_y.push_back(int'(ypixel_o));
        end
      end
      if (frame_done === 1'b1) n_done++;
    end
    nd = -1;
    if (reset) begin
      m_phase = 0;
      m_n = 0;
      m_rr = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_n = 0;
          m_rr = 0;
        end
        1: begin
          for (int k = 0; k < N; k++) begin
            g = (m_rr + k) % N;
            if (nd < 0 && engine_idle[g] && !queue_full[g] && g != m_disp) nd = g;
          end
          if (nd >= 0) begin
            m_cx = m_n % XR;
            m_cy = m_n / XR;
            m_n++;
            m_rr = (nd + 1) % N;
            if (m_n == TOTAL) m_phase = 2;
          end
        end
        2: if (m_disp < 0 && engine_idle == '1) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    m_disp = nd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_eng.delete();
    log_x.delete();
    log_y.delete();
  endtask

  task automatic wait_grants(input int target);
    int c = 0;
    while (log_x.size() < target && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) check_int("timeout_grants", log_x.size(), target);
  endtask

  task automatic wait_done(input int base);
    int c = 0;
    while (n_done == base && c < 300) begin
      tick();
      c++;
    end
    if (c >= 300) check_int("timeout_done", n_done - base, 1);
    repeat (3) tick();
  endtask

  task automatic check_order(input string name);
    check_int({name, "_count"}, log_x.size(), TOTAL);
    for (int i = 0; i < log_x.size() && i < TOTAL; i++) begin
      check_int({name, "_x"}, log_x[i], i % XR);
      check_int({name, "_y"}, log_y[i], i / XR);
    end
  endtask

  initial begin
    int base;
    int eng0;
    reset = 1'b1;
    start = 1'b0;
    engine_idle = 2'b11;
    queue_full = 2'b00;
    tick();
    check_en = 1'b1;
    tick();
    check_int("reset_dispatch", int'(dispatch), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_xpixel", int'(xpixel_o), 0);
    reset = 1'b0;
    tick();

    // Basic frame: engines alternate 0,1,0,1...
    clear_log();
    base = n_done;
    pulse_start();
    wait_done(base);
    check_order("basic");
    check_int("basic_eng0", log_eng[0], 0);
    check_int("basic_eng1", log_eng[1], 1);
    check_int("basic_eng4", log_eng[4], 0);
    check_int("basic_eng7", log_eng[7], 1);
    check_int("basic_last_x", log_x[7], 3);
    check_int("basic_last_y", log_y[7], 1);
    check_int("basic_done", n_done - base, 1);
    check_int("basic_busy", int'(busy), 0);

    // Engine 1 blocked by a full queue: everything goes to engine 0.
    queue_full = 2'b10;
    clear_log();
    base = n_done;
    pulse_start();
    wait_done(base);
    check_order("qfull");
    eng0 = 0;
    foreach (log_eng[i]) if (log_eng[i] == 0) eng0++;
    check_int("qfull_all_eng0", eng0, 8);
    check_int("qfull_done", n_done - base, 1);
    queue_full = 2'b00;

    // Stall mid-frame with no engine ready.
    clear_log();
    base = n_done;
    pulse_start();
    wait_grants(3);
    engine_idle = 2'b00;
    repeat (5) tick();
    engine_idle = 2'b11;
    wait_done(base);
    check_order("stall");
    check_int("stall_done", n_done - base, 1);

    // Drain held off by a busy engine.
    clear_log();
    base = n_done;
    pulse_start();
    wait_grants(8);
    engine_idle = 2'b01;
    repeat (10) tick();
    check_int("drain_withheld", n_done - base, 0);
    check_int("drain_busy", int'(busy), 1);
    engine_idle = 2'b11;
    wait_done(base);
    check_int("drain_done", n_done - base, 1);

    // Reset mid-frame, then restart from (0,0) on engine 0.
    clear_log();
    base = n_done;
    pulse_start();
    wait_grants(3);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check_int("abort_no_done", n_done - base, 0);
    check_int("abort_busy", int'(busy), 0);
    clear_log();
    pulse_start();
    wait_done(base);
    check_int("restart_eng", log_eng[0], 0);
    check_int("restart_x", log_x[0], 0);
    check_int("restart_y", log_y[0], 0);
    check_order("restart");
    check_int("restart_done", n_done - base, 1);

    // Start pulses during DISPATCH and DRAIN are ignored.
    clear_log();
    base = n_done;
    pulse_start();
    wait_grants(2);
    pulse_start();
    wait_grants(8);
    pulse_start();
    wait_done(base);
    repeat (5) tick();
    check_order("ignore_start");
    check_int("ignore_start_done", n_done - base, 1);
    check_int("ignore_start_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
